// File: rtl/coin_change_dispenser_pkg.sv
// rtl/coin_change_dispenser_pkg.sv - shared state encodings and coin codes for the change dispenser
package coin_change_dispenser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Same encoding as the vending FSM's coin_in bus
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

endpackage

// File: rtl/coin_change_dispenser_if.sv
// rtl/coin_change_dispenser_if.sv - refund request and hopper handshake bundle
interface coin_change_dispenser_if #(
   parameter int UNIT_W = 6
);
   logic              req_valid;
   logic [UNIT_W-1:0] req_units;
   logic              req_ready;
   logic              coin_valid;
   logic [1:0]        coin_out;
   logic              coin_ack;

   // master = requester plus hopper side, slave = dispenser
   modport master (output req_valid, req_units, coin_ack,
                   input  req_ready, coin_valid, coin_out);
   modport slave  (input  req_valid, req_units, coin_ack,
                   output req_ready, coin_valid, coin_out);
endinterface

// File: rtl/coin_change_dispenser_stock.sv
// rtl/coin_change_dispenser_stock.sv - saturating per-denomination coin stock counter
module coin_stock_counter #(
   parameter int W    = 6,
   parameter int INIT = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         refill,
   input  logic         take,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] MAX_V  = '1;
   localparam logic [W-1:0] INIT_V = W'(INIT);

   // Refill saturates at all-ones; a refill and a take together cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= INIT_V;
      else if (refill && !take && count != MAX_V)
         count <= count + 1'b1;
      else if (take && !refill && count != '0)
         count <= count - 1'b1;
   end
endmodule

// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - greedy Rs.10/Rs.5 change payout over a hopper valid/ack handshake
module coin_change_dispenser
   import coin_change_dispenser_pkg::*;
#(
   parameter int UNIT_W       = 6,
   parameter int STOCK_W      = 6,
   parameter int INIT_STOCK5  = 20,
   parameter int INIT_STOCK10 = 20,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   coin_change_dispenser_if.slave bus,
   input  logic                 refill5,
   input  logic                 refill10,
   output logic [STOCK_W-1:0]   stock5,
   output logic [STOCK_W-1:0]   stock10,
   output logic                 busy,
   output logic                 done,
   output logic                 short_chg,
   output logic [UNIT_W-1:0]    shortfall,
   output logic                 fault
);
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state;
   logic [UNIT_W-1:0] rem;
   logic [1:0]        coin;
   logic [TMO_W-1:0]  tmo;
   logic              acked;
   logic              take5;
   logic              take10;

   // A coin leaves stock only when the hopper acknowledges the presented coin
   assign acked  = (state == ST_ISSUE) && bus.coin_valid && bus.coin_ack;
   assign take5  = acked && (coin == COIN_5);
   assign take10 = acked && (coin == COIN_10);

   coin_stock_counter #(.W(STOCK_W), .INIT(INIT_STOCK5)) u_stock5 (
      .clk    (clk),
      .rst    (rst),
      .refill (refill5),
      .take   (take5),
      .count  (stock5)
   );

   coin_stock_counter #(.W(STOCK_W), .INIT(INIT_STOCK10)) u_stock10 (
      .clk    (clk),
      .rst    (rst),
      .refill (refill10),
      .take   (take10),
      .count  (stock10)
   );

   // Payout FSM; every output is registered and follows the state it is set in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         rem            <= '0;
         coin           <= COIN_NONE;
         tmo            <= '0;
         bus.req_ready  <= 1'b1;
         bus.coin_valid <= 1'b0;
         bus.coin_out   <= COIN_NONE;
         busy           <= 1'b0;
         done           <= 1'b0;
         short_chg      <= 1'b0;
         shortfall      <= '0;
         fault          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && !fault) begin
                  rem           <= bus.req_units;
                  state         <= ST_SELECT;
                  bus.req_ready <= 1'b0;
                  busy          <= 1'b1;
               end
            end
            ST_SELECT: begin
               if (rem >= UNIT_W'(2) && stock10 != '0) begin
                  coin  <= COIN_10;
                  state <= ST_ISSUE;
               end else if (rem != '0 && stock5 != '0) begin
                  coin  <= COIN_5;
                  state <= ST_ISSUE;
               end else begin
                  state <= ST_FINISH;
               end
            end
            ST_ISSUE: begin
               if (!bus.coin_valid) begin
                  // tmo counts the cycles coin_valid has been high
                  bus.coin_valid <= 1'b1;
                  bus.coin_out   <= coin;
                  tmo            <= TMO_W'(1);
               end else if (bus.coin_ack) begin
                  bus.coin_valid <= 1'b0;
                  bus.coin_out   <= COIN_NONE;
                  rem            <= rem - ((coin == COIN_10) ? UNIT_W'(2) : UNIT_W'(1));
                  state          <= ST_SELECT;
               end else if (tmo == TMO_W'(ACK_TIMEOUT)) begin
                  // Hopper is stuck: abandon the coin and stop accepting work
                  bus.coin_valid <= 1'b0;
                  bus.coin_out   <= COIN_NONE;
                  fault          <= 1'b1;
                  state          <= ST_FINISH;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            ST_FINISH: begin
               done          <= 1'b1;
               short_chg     <= (rem != '0);
               shortfall     <= rem;
               state         <= ST_IDLE;
               bus.req_ready <= 1'b1;
               busy          <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb/tb_coin_change_dispenser.sv - directed scoreboard bench for coin_change_dispenser
module tb_coin_change_dispenser;
   import coin_change_dispenser_pkg::*;

   localparam int UNIT_W  = 6;
   localparam int STOCK_W = 6;
   localparam int INIT5   = 20;
   localparam int INIT10  = 20;
   localparam int TMO     = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               refill5;
   logic               refill10;
   logic [STOCK_W-1:0] stock5;
   logic [STOCK_W-1:0] stock10;
   logic               busy;
   logic               done;
   logic               short_chg;
   logic [UNIT_W-1:0]  shortfall;
   logic               fault;

   coin_change_dispenser_if #(.UNIT_W(UNIT_W)) bus ();

   coin_change_dispenser #(
      .UNIT_W       (UNIT_W),
      .STOCK_W      (STOCK_W),
      .INIT_STOCK5  (INIT5),
      .INIT_STOCK10 (INIT10),
      .ACK_TIMEOUT  (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .refill5   (refill5),
      .refill10  (refill10),
      .stock5    (stock5),
      .stock10   (stock10),
      .busy      (busy),
      .done      (done),
      .short_chg (short_chg),
      .shortfall (shortfall),
      .fault     (fault)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case anything escapes its own cycle bound
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   int         vectors    = 0;
   int         miscompares = 0;
   logic [1:0] exp_q[$];
   int         m5;
   int         m10;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Greedy payout model over the bench's own stock copy
   task automatic push_model(input int units, input bit pay, output int exp_short);
      int rem;
      int s5;
      int s10;
      rem = units;
      s5  = m5;
      s10 = m10;
      exp_q.delete();
      while (rem > 0) begin
         if (rem >= 2 && s10 > 0) begin
            exp_q.push_back(COIN_10);
            s10--;
            rem -= 2;
         end else if (s5 > 0) begin
            exp_q.push_back(COIN_5);
            s5--;
            rem -= 1;
         end else begin
            break;
         end
         if (!pay) break;
      end
      if (pay) begin
         m5        = s5;
         m10       = s10;
         exp_short = rem;
      end else begin
         exp_short = units;
      end
   endtask

   task automatic pulse_refill(input bit ten, input int n);
      @(negedge clk);
      if (ten) refill10 = 1'b1; else refill5 = 1'b1;
      repeat (n) @(negedge clk);
      refill5  = 1'b0;
      refill10 = 1'b0;
   endtask

   task automatic run_request(input string tag, input int units, input bit ack_en, input bit refill_on_ack);
      int         exp_short;
      int         first_valid;
      int         valid_cycles;
      int         tens;
      int         done_at;
      bit         ack_was;
      bit         had_coins;
      logic [1:0] e;
      push_model(units, ack_en, exp_short);
      had_coins    = (exp_q.size() > 0);
      first_valid  = 0;
      valid_cycles = 0;
      tens         = 0;
      done_at      = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_units = units[UNIT_W-1:0];
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         if (i == 1) bus.req_valid = 1'b0;
         ack_was      = bus.coin_ack;
         bus.coin_ack = 1'b0;
         refill10     = 1'b0;
         if (bus.coin_valid) begin
            valid_cycles++;
            if (first_valid == 0) first_valid = i;
            if ((ack_en && !ack_was) || (!ack_en && valid_cycles == 1)) begin
               if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 2'b11;
               check({tag, " coin"}, bus.coin_out, e);
               if (ack_en) begin
                  bus.coin_ack = 1'b1;
                  if (e == COIN_10) begin
                     tens++;
                     if (refill_on_ack) refill10 = 1'b1;
                  end
               end
            end
         end
         if (done) begin
            done_at = i;
            break;
         end
      end
      bus.coin_ack = 1'b0;
      refill10     = 1'b0;
      if (refill_on_ack) m10 += tens;
      check({tag, " done seen"}, (done_at != 0), 1);
      check({tag, " short_chg"}, short_chg, (exp_short != 0));
      check({tag, " shortfall"}, shortfall, exp_short);
      check({tag, " coins left"}, exp_q.size(), 0);
      if (had_coins) check({tag, " first valid"}, first_valid, 3);
      else           check({tag, " done latency"}, done_at, 3);
      check({tag, " stock5"}, stock5, m5);
      check({tag, " stock10"}, stock10, m10);
      if (!ack_en) begin
         check({tag, " valid cycles"}, valid_cycles, TMO);
         check({tag, " fault"}, fault, 1);
      end
   endtask

   initial begin
      rst           = 1'b1;
      refill5       = 1'b0;
      refill10      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_units = '0;
      bus.coin_ack  = 1'b0;
      m5            = INIT5;
      m10           = INIT10;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst coin_valid", bus.coin_valid, 0);
      check("rst coin_out", bus.coin_out, COIN_NONE);
      check("rst req_ready", bus.req_ready, 1);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst short_chg", short_chg, 0);
      check("rst shortfall", shortfall, 0);
      check("rst fault", fault, 0);
      check("rst stock5", stock5, INIT5);
      check("rst stock10", stock10, INIT10);

      // 3 units -> Rs.10 then Rs.5
      run_request("three", 3, 1'b1, 1'b0);

      // Drain Rs.10 stock, then 4 units must go out as Rs.5 coins
      run_request("drain10", 38, 1'b1, 1'b0);
      run_request("four_by5", 4, 1'b1, 1'b0);

      // Leave one Rs.5 coin, then ask for 3 units -> shortfall 2
      run_request("drain5", 14, 1'b1, 1'b0);
      run_request("short", 3, 1'b1, 1'b0);

      // Refill10 on the same edge as a Rs.10 ack leaves stock10 unchanged
      pulse_refill(1'b1, 2);
      m10 += 2;
      check("refill10 x2", stock10, m10);
      run_request("refill_ack", 2, 1'b1, 1'b1);

      // Refill well past full saturates the Rs.5 counter
      pulse_refill(1'b0, 70);
      m5 = (1 << STOCK_W) - 1;
      check("refill5 saturate", stock5, m5);

      // Hopper never acks -> timeout, fault, whole amount short
      run_request("timeout", 3, 1'b0, 1'b0);

      // With fault set a new request is refused
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_units = 6'd2;
      repeat (4) @(negedge clk);
      check("fault refuse busy", busy, 0);
      check("fault refuse valid", bus.coin_valid, 0);
      bus.req_valid = 1'b0;

      // Reset clears fault and reloads stock
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m5  = INIT5;
      m10 = INIT10;
      @(negedge clk);
      check("rst2 fault", fault, 0);
      check("rst2 stock10", stock10, INIT10);

      // Reset while a coin is being presented
      bus.req_valid = 1'b1;
      bus.req_units = 6'd4;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int k = 0; k < 20 && !bus.coin_valid; k++) @(negedge clk);
      check("midpay coin_valid up", bus.coin_valid, 1);
      rst = 1'b1;
      #1;
      check("midpay coin_valid", bus.coin_valid, 0);
      check("midpay busy", busy, 0);
      check("midpay req_ready", bus.req_ready, 1);
      check("midpay stock5", stock5, INIT5);
      check("midpay stock10", stock10, INIT10);
      @(negedge clk);
      rst = 1'b0;

      // Zero-unit request finishes without coins
      run_request("zero", 0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
